// File: rtl/seven_seg_scan.sv
// Six-digit multiplexed seven-segment driver for an HH:MM:SS clock.
// A scan counter steps through the digits; time fields are snapshotted once
// per frame so a display frame is always self-consistent. The selected edit
// field blinks at a rate set in whole frames.
module seven_seg_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sec_in,
    input  logic [5:0] min_in,
    input  logic [4:0] hour_in,
    input  logic [1:0] select,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic [BW-1:0] frame_cnt;
    logic          blink_phase;
    logic [5:0]    sec_s;
    logic [5:0]    min_s;
    logic [4:0]    hour_s;

    logic scan_tc;
    logic frame_wrap;
    logic frame_tc;

    assign scan_tc    = (scan_cnt == SW'(SCAN_DIV - 1));
    assign frame_wrap = scan_tc && (idx == 3'd5);
    assign frame_tc   = (frame_cnt == BW'(BLINK_DIV - 1));

    // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h3F;
        endcase
    endfunction

    logic [5:0] fval;
    logic       fok;
    logic [5:0] tens;
    logic [5:0] ones;
    logic [3:0] digit;
    logic       blank;
    logic [5:0] an_nxt;
    logic [6:0] seg_nxt;
    logic       dp_nxt;

    // Pick the field for the current digit, split it, and form next outputs.
    always_comb begin
        fval = 6'd0;
        fok  = 1'b1;
        case (idx[2:1])
            2'd0: begin
                fval = sec_s;
                fok  = (sec_s < 6'd60);
            end
            2'd1: begin
                fval = min_s;
                fok  = (min_s < 6'd60);
            end
            default: begin
                fval = {1'b0, hour_s};
                fok  = (hour_s < 5'd24);
            end
        endcase
        tens    = fval / 6'd10;
        ones    = fval % 6'd10;
        digit   = idx[0] ? tens[3:0] : ones[3:0];
        seg_nxt = fok ? enc(digit) : 7'h3F;
        // select 1..3 maps to field 0..2 (idx[2:1]); select 0 never blanks
        blank   = blink_phase && (select != 2'd0) && (idx[2:1] == (select - 2'd1));
        an_nxt  = blank ? 6'h3F : ~(6'd1 << idx);
        if (blank)
            seg_nxt = 7'h7F;
        // dp marks the separators right of the minutes and hours fields
        dp_nxt  = !((idx == 3'd2) || (idx == 3'd4));
    end

    // Scan, frame and blink counters plus the once-per-frame time snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt    <= '0;
            idx         <= 3'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            sec_s       <= 6'd0;
            min_s       <= 6'd0;
            hour_s      <= 5'd0;
        end else begin
            if (scan_tc) begin
                scan_cnt <= '0;
                idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            if (frame_wrap) begin
                sec_s  <= sec_in;
                min_s  <= min_in;
                hour_s <= hour_in;
                if (frame_tc) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + BW'(1);
                end
            end
        end
    end

    // Registered display outputs, one cycle behind the scan state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 6'h3F;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with SCAN_DIV=2, BLINK_DIV=2.
// Outputs are sampled on the falling edge as {an,seg,dp}.
module tb_seven_seg_scan;

    logic       clk;
    logic       reset;
    logic       run;
    logic [5:0] sec_in;
    logic [5:0] min_in;
    logic [4:0] hour_in;
    logic [1:0] select;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks;
    int errors;

    seven_seg_scan #(.SCAN_DIV(2), .BLINK_DIV(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .sec_in (sec_in),
        .min_in (min_in),
        .hour_in(hour_in),
        .select (select),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    // Clock only toggles once run is set, so async reset can be seen alone.
    initial begin
        clk = 1'b0;
        forever #5 clk = run ? ~clk : clk;
    end

    task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                     tag, got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
        end
    endtask

    // One cycle: wait for the falling edge then compare.
    task automatic cyc(input string tag, input logic [13:0] exp);
        @(negedge clk);
        chk(tag, {an, seg, dp}, exp);
    endtask

    // One digit slot is two cycles with SCAN_DIV=2.
    task automatic dig(input string tag, input logic [13:0] exp);
        cyc(tag, exp);
        cyc(tag, exp);
    endtask

    task automatic frame(input string tag,
                         input logic [13:0] e0, input logic [13:0] e1, input logic [13:0] e2,
                         input logic [13:0] e3, input logic [13:0] e4, input logic [13:0] e5);
        dig({tag, "_d0"}, e0);
        dig({tag, "_d1"}, e1);
        dig({tag, "_d2"}, e2);
        dig({tag, "_d3"}, e3);
        dig({tag, "_d4"}, e4);
        dig({tag, "_d5"}, e5);
    endtask

    localparam logic [13:0] RST = {6'h3F, 7'h7F, 1'b1};

    initial begin
        checks  = 0;
        errors  = 0;
        run     = 1'b0;
        reset   = 1'b0;
        sec_in  = 6'd37;
        min_in  = 6'd5;
        hour_in = 5'd23;
        select  = 2'd0;

        // async reset with the clock stopped
        #2 reset = 1'b1;
        #1 chk("rst_async", {an, seg, dp}, RST);
        run = 1'b1;
        @(negedge clk);
        chk("rst_held", {an, seg, dp}, RST);
        reset = 1'b0;

        // frame A: zero snapshot, index 0 first
        frame("zero", {6'h3E,7'h40,1'b1}, {6'h3D,7'h40,1'b1}, {6'h3B,7'h40,1'b0},
                      {6'h37,7'h40,1'b1}, {6'h2F,7'h40,1'b0}, {6'h1F,7'h40,1'b1});

        // frame B: 23:05:37; sec changes during digit 3 must not show yet
        dig("t_d0", {6'h3E,7'h78,1'b1});
        dig("t_d1", {6'h3D,7'h30,1'b1});
        dig("t_d2", {6'h3B,7'h12,1'b0});
        sec_in = 6'd12;
        dig("t_d3", {6'h37,7'h40,1'b1});
        dig("t_d4", {6'h2F,7'h30,1'b0});
        dig("t_d5", {6'h1F,7'h24,1'b1});

        // frame C: blink phase on, select 0 keeps all digits; then select hours
        dig("s0_d0", {6'h3E,7'h24,1'b1});
        dig("s0_d1", {6'h3D,7'h79,1'b1});
        dig("s0_d2", {6'h3B,7'h12,1'b0});
        select = 2'd3;
        dig("s3_d3", {6'h37,7'h40,1'b1});
        dig("s3_d4", {6'h3F,7'h7F,1'b0});
        dig("s3_d5", {6'h3F,7'h7F,1'b1});

        // frame D: still blanking; clearing select restores hours next cycle
        dig("bl_d0", {6'h3E,7'h24,1'b1});
        dig("bl_d1", {6'h3D,7'h79,1'b1});
        dig("bl_d2", {6'h3B,7'h12,1'b0});
        dig("bl_d3", {6'h37,7'h40,1'b1});
        cyc("bl_d4", {6'h3F,7'h7F,1'b0});
        select = 2'd0;
        cyc("unbl_d4", {6'h2F,7'h30,1'b0});
        dig("unbl_d5", {6'h1F,7'h24,1'b1});
        select = 2'd3;
        min_in = 6'd60;

        // frame E: blink phase off, select 3 shows hours
        frame("ph0", {6'h3E,7'h24,1'b1}, {6'h3D,7'h79,1'b1}, {6'h3B,7'h12,1'b0},
                     {6'h37,7'h40,1'b1}, {6'h2F,7'h30,1'b0}, {6'h1F,7'h24,1'b1});

        // frame F: minutes out of range show dashes
        frame("dash", {6'h3E,7'h24,1'b1}, {6'h3D,7'h79,1'b1}, {6'h3B,7'h3F,1'b0},
                      {6'h37,7'h3F,1'b1}, {6'h2F,7'h30,1'b0}, {6'h1F,7'h24,1'b1});

        // frame G: blink phase on again; reset during digit 4
        dig("g_d0", {6'h3E,7'h24,1'b1});
        dig("g_d1", {6'h3D,7'h79,1'b1});
        dig("g_d2", {6'h3B,7'h3F,1'b0});
        dig("g_d3", {6'h37,7'h3F,1'b1});
        cyc("g_d4", {6'h3F,7'h7F,1'b0});
        #2 reset = 1'b1;
        #1 chk("rst_mid", {an, seg, dp}, RST);
        @(negedge clk);
        chk("rst_mid_held", {an, seg, dp}, RST);
        reset = 1'b0;

        // restart at index 0 with zero snapshot and blink phase cleared
        frame("rezero", {6'h3E,7'h40,1'b1}, {6'h3D,7'h40,1'b1}, {6'h3B,7'h40,1'b0},
                        {6'h37,7'h40,1'b1}, {6'h2F,7'h40,1'b0}, {6'h1F,7'h40,1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles each digit is driven; legal range >=1.
REQ-002 SHALL have parameter BLINK_DIV, default 40, full scan frames per blink half-period; legal range >=1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 sec_in  input  6  binary seconds from the clock stage; legal 0..59.
REQ-006 min_in  input  6  binary minutes; legal 0..59.
REQ-007 hour_in  input  5  binary hours; legal 0..23.
REQ-008 select  input  2  edit field: 0 none, 1 seconds, 2 minutes, 3 hours.
REQ-009 an  output  6  digit enables, active-low, one-hot-zero.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 SHALL keep a scan counter 0..SCAN_DIV-1; at terminal count it wraps to 0 and the digit index (0..5) advances by 1, wrapping 5->0.
REQ-013 Digit index map SHALL be: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hour ones, 5 hour tens; index k drives an[k]=0, all other an bits 1.
REQ-014 SHALL snapshot sec_in, min_in, hour_in into internal registers on the edge where the index wraps 5->0; input changes at any other time SHALL NOT affect the displayed frame.
REQ-015 Digit values SHALL be tens = v/10, ones = v%10 of the snapshot field.
REQ-016 Digit encoding (hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-017 Snapshot field out of range (sec/min >=60, hour >=24) SHALL display dash (seg=3F) on both of its digits.
REQ-018 dp SHALL be 0 while index is 2 or 4 (field separators), else 1; dp is never blanked.
REQ-019 SHALL keep a frame counter 0..BLINK_DIV-1 advanced at every 5->0 index wrap; at its terminal count it wraps and blink_phase toggles.
REQ-020 When blink_phase=1 and select is nonzero, the two digits of the selected field SHALL be blanked: an bit held 1, seg=7F; select is sampled live each cycle.
REQ-021 select=0 SHALL never blank; blink counters SHALL run regardless of select.
REQ-022 an, seg, dp SHALL be registered: they reflect index, snapshot, blink_phase and select of the previous cycle (1-cycle latency).
REQ-023 With SCAN_DIV=1 the index SHALL advance every cycle; no cycle with all an bits 1 SHALL occur except blanking or reset.

Reset
REQ-024 On reset assertion, immediately: an=3F, seg=7F, dp=1, scan counter 0, index 0, frame counter 0, blink_phase 0, snapshots 0.
REQ-025 First rising clk edge after reset release SHALL drive index 0 from snapshot 0 (an=3E, seg=40, dp=1); no initial snapshot load occurs until the first 5->0 wrap.
REQ-026 Reset asserted mid-frame SHALL abort the frame; scanning restarts at index 0 with zeroed snapshots.

Verification (SCAN_DIV=2, BLINK_DIV=2 unless stated)
REQ-027 Reset held -> an=3F, seg=7F, dp=1 with no clock edge required; release -> an=3E, seg=40 next edge.
REQ-028 sec_in=37, min_in=5, hour_in=23, select=0, after first wrap -> frame sequence (an,seg,dp), each held 2 cycles: (3E,78,1),(3D,30,1),(3B,12,0),(37,40,1),(2F,30,0),(1F,24,1).
REQ-029 Change sec_in 37->12 while index=3 -> rest of frame unchanged; next frame shows 2,1 on digits 0,1.
REQ-030 select=3, steady inputs -> hour digits show an=3F, seg=7F on frames 3-4, 7-8, ... (12-cycle frames, toggle every 24 cycles); other digits unaffected; select=0 mid-blink -> hours reappear next cycle.
REQ-031 min_in=60 -> digits 2,3 seg=3F, digit 2 dp=0; sec and hour digits normal.
REQ-032 Assert reset during index 4 -> outputs reset same cycle; after release scan restarts at index 0 showing 0.
